fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer/flag controller that sequences a synchronous dual-port FIFO RAM (sync write, registered read, 1-cycle read latency, no reset on the array) into a first-word-fall-through FIFO.
- Upstream side is a valid/ready push interface; downstream side is a valid/ready pop interface with read data taken straight from the RAM output register.
- Owns all RAM address/enable generation, full/empty tracking and read-latency hiding, so the sustained rate is one push and one pop per cycle.

Parameters:
- DataWidth, 8, word width; must match the RAM.
- Depth, 16, number of entries; power of two, >= 2.
- AddrWidth, $clog2(Depth), localparam; RAM address width. Internal pointers are AddrWidth+1 bits.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_valid  in  1  push request.
- o_wr_ready  out  1  push accepted when i_wr_valid && o_wr_ready.
- i_wr_data  in  DataWidth  push data.
- o_rd_valid  out  1  o_rd_data holds the head entry.
- i_rd_ready  in  1  pop when o_rd_valid && i_rd_ready.
- o_rd_data  out  DataWidth  head entry; combinational pass-through of i_mem_rd_data.
- o_mem_wr_en  out  1  RAM write enable; equals push.
- o_mem_wr_addr  out  AddrWidth  wr_ptr[AddrWidth-1:0].
- o_mem_wr_data  out  DataWidth  equals i_wr_data.
- o_mem_rd_addr  out  AddrWidth  pop ? rd_ptr+1 : rd_ptr, low AddrWidth bits.
- i_mem_rd_data  in  DataWidth  RAM registered read data.

Behaviour:
- Reset: while i_rst is high, the next edge sets wr_ptr, rd_ptr and wr_ptr_d1 to 0. During the reset cycle, o_wr_ready=0, o_rd_valid=0 and o_mem_wr_en=0. RAM contents are untouched and are never relied on after reset.
- Reset mid-operation: all in-flight and stored entries are discarded. The first cycle after reset deasserts, o_wr_ready=1 and o_rd_valid=0.
- push = i_wr_valid && o_wr_ready; wr_ptr increments by 1 on push.
- pop = o_rd_valid && i_rd_ready; rd_ptr increments by 1 on pop.
- Pointers wrap naturally modulo 2*Depth. The MSB distinguishes full from empty.
- wr_ptr_d1 is wr_ptr registered one cycle. It models the RAM write-then-read latency.
- o_rd_valid = (rd_ptr != wr_ptr_d1).
- Write-to-read latency: a push accepted in cycle N makes o_rd_valid=1 with its data in cycle N+2, provided no older entries are pending.
- o_mem_rd_addr is the look-ahead address, so i_mem_rd_data in cycle t equals mem[rd_ptr(t)]. Back-to-back pops therefore see successive entries with no bubble.
- Full: (wr_ptr - rd_ptr) == Depth, giving o_wr_ready=0.
  - o_wr_ready depends only on registered state; there is no combinational path from i_rd_ready.
  - Full plus a pop in the same cycle: the push is refused that cycle and ready rises the following cycle.
- Empty plus a push: the entry is not poppable until N+2; o_rd_valid stays 0 in N and N+1.
- Push and pop in the same cycle (not full, o_rd_valid=1): both are accepted and occupancy is unchanged.
- Read/write address collision: only possible when the write slot differs from the head, or the FIFO is empty. The wr_ptr_d1 gating guarantees the RAM's old-data collision result is never presented as valid.
- Pop with o_rd_valid=0 is ignored. Push with o_wr_ready=0 is ignored, with no RAM write.
- Ordering is strict FIFO; there is no data loss or duplication.

Optional Feature:
- Macro: FIFO_CTRL_LEVEL_EN.
- Defined: adds output o_level (AddrWidth+1 bits) = wr_ptr - rd_ptr, registered, reset 0. It counts accepted pushes minus pops and reaches Depth when full, including entries in the 2-cycle visibility window.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> o_rd_valid=0, o_wr_ready=1, o_mem_wr_en=0 (o_level=0 if enabled).
- Single push 8'hA5 in cycle N, i_rd_ready=1 -> o_rd_valid=0 in N and N+1, then o_rd_valid=1 with o_rd_data=8'hA5 in N+2, and o_rd_valid=0 in N+3.
- 16 pushes 0x00..0x0F with no pops -> o_wr_ready=0 after the 16th; a 17th push 0xFF is not written. Then 16 pops with i_rd_ready=1 return 0x00..0x0F on consecutive cycles.
- Full, then push 0x55 and pop in the same cycle -> pop returns 0x00, push refused. Next cycle o_wr_ready=1 and 0x55 is accepted; it is later popped as the 17th word after 0x0F.
- Continuous push and pop of 100 incrementing words with random i_rd_ready/i_wr_valid (50%) -> output sequence matches input, pointers wrap past 31 correctly, no bubble when both sides are always active (1 word/cycle after the initial 2-cycle fill).
- Assert i_rst with 7 entries stored and a push in flight -> next cycle o_rd_valid=0, o_wr_ready=1. Push 0x3C -> 0x3C is the first word popped.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller that turns a synchronous dual-port
// RAM (sync write, registered read, one-cycle read latency) into a
// first-word-fall-through FIFO with valid/ready push and pop interfaces.
//
// Ports:
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_wr_valid/o_wr_ready/i_wr_data   push interface
//   o_rd_valid/i_rd_ready/o_rd_data   pop interface (data straight from RAM)
//   o_mem_wr_en/o_mem_wr_addr/o_mem_wr_data   RAM write port
//   o_mem_rd_addr/i_mem_rd_data               RAM read port
//   o_level              occupancy (only when FIFO_CTRL_LEVEL_EN is defined)
//
// Build option: define FIFO_CTRL_LEVEL_EN to add the registered o_level output.
module fifo_ctrl #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    localparam int AddrWidth = $clog2(Depth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [DataWidth-1:0] i_wr_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [DataWidth-1:0] o_rd_data,
    output logic                 o_mem_wr_en,
    output logic [AddrWidth-1:0] o_mem_wr_addr,
    output logic [DataWidth-1:0] o_mem_wr_data,
    output logic [AddrWidth-1:0] o_mem_rd_addr,
    input  logic [DataWidth-1:0] i_mem_rd_data
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [AddrWidth:0]   o_level
`endif
);

    localparam int PtrWidth = AddrWidth + 1;
    localparam logic [PtrWidth-1:0] DepthVal = PtrWidth'(Depth);

    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr_d1;
    logic [PtrWidth-1:0] used;
    logic                push;
    logic                pop;

    // Occupancy counts entries still inside the RAM write-to-read window,
    // so ready never depends on the pop side in the same cycle.
    assign used       = wr_ptr - rd_ptr;
    assign o_wr_ready = ~i_rst & (used != DepthVal);

    // Comparing against the delayed write pointer hides the RAM latency and
    // keeps a same-address old-data read from ever being presented as valid.
    assign o_rd_valid = ~i_rst & (rd_ptr != wr_ptr_d1);

    assign push = i_wr_valid & o_wr_ready;
    assign pop  = o_rd_valid & i_rd_ready;

    assign o_mem_wr_en   = push;
    assign o_mem_wr_addr = wr_ptr[AddrWidth-1:0];
    assign o_mem_wr_data = i_wr_data;

    // Look-ahead read address: the RAM output register then always holds
    // the entry at the pointer value of the following cycle.
    assign o_mem_rd_addr = rd_ptr[AddrWidth-1:0] + AddrWidth'(pop);
    assign o_rd_data     = i_mem_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ptr_d1 <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PtrWidth'(push);
            rd_ptr    <= rd_ptr + PtrWidth'(pop);
            wr_ptr_d1 <= wr_ptr;
        end
    end

`ifdef FIFO_CTRL_LEVEL_EN
    // Tracks wr_ptr - rd_ptr in its own register so the output is a flop.
    logic [AddrWidth:0] level_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_q + PtrWidth'(push) - PtrWidth'(pop);
        end
    end

    assign o_level = level_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic [7:0] i_wr_data;
    logic       o_rd_valid;
    logic       i_rd_ready;
    logic [7:0] o_rd_data;
    logic       o_mem_wr_en;
    logic [3:0] o_mem_wr_addr;
    logic [7:0] o_mem_wr_data;
    logic [3:0] o_mem_rd_addr;
    logic [7:0] i_mem_rd_data;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [4:0] o_level;
`endif

    fifo_ctrl #(.DataWidth(8), .Depth(16)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_data     (i_wr_data),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_rd_data     (o_rd_data),
        .o_mem_wr_en   (o_mem_wr_en),
        .o_mem_wr_addr (o_mem_wr_addr),
        .o_mem_wr_data (o_mem_wr_data),
        .o_mem_rd_addr (o_mem_rd_addr),
        .i_mem_rd_data (i_mem_rd_data)
`ifdef FIFO_CTRL_LEVEL_EN
        ,
        .o_level       (o_level)
`endif
    );

    always #5 i_clk = ~i_clk;

    // RAM: synchronous write, registered read, no reset on the array.
    logic [7:0] mem [0:15];
    always @(posedge i_clk) begin
        if (o_mem_wr_en) mem[o_mem_wr_addr] <= o_mem_wr_data;
        i_mem_rd_data <= mem[o_mem_rd_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Scoreboard-driven traffic: an entry becomes poppable two cycles after
    // its push, and ready drops when sixteen entries are outstanding.
    task automatic run_traffic(input int nwords, input bit always_on);
        int   pushed = 0;
        int   budget = 0;
        logic [7:0] next_val = 8'h00;
        logic exp_valid;
        logic exp_ready;
        while (!(pushed >= nwords && q.size() == 0)) begin
            tick();
            i_wr_valid = (pushed < nwords) ? (always_on ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            i_rd_ready = always_on ? 1'b1 : 1'($urandom_range(0, 1));
            i_wr_data  = next_val;
            #1;
            exp_valid = (q.size() > 0) && (cyc >= q[0].c + 2);
            exp_ready = (q.size() != 16);
            chk("trf_valid", o_rd_valid, exp_valid);
            chk("trf_ready", o_wr_ready, exp_ready);
            chk("trf_wr_en", o_mem_wr_en, i_wr_valid & exp_ready);
`ifdef FIFO_CTRL_LEVEL_EN
            chk("trf_level", o_level, q.size());
`endif
            if (exp_valid && i_rd_ready) begin
                chk("trf_data", o_rd_data, q[0].d);
                void'(q.pop_front());
            end
            if (i_wr_valid && exp_ready) begin
                q.push_back('{next_val, cyc});
                next_val++;
                pushed++;
            end
            budget++;
            if (budget > 3000) begin
                chk("trf_timeout", 32'(budget), 32'd3000);
                q.delete();
                break;
            end
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_wr_valid = 1'b1;
        i_rd_ready = 1'b1;
        i_wr_data  = 8'h11;

        // Reset cycles: nothing ready, nothing valid, no RAM write.
        tick();
        chk("rst_ready", o_wr_ready, 1'b0);
        chk("rst_valid", o_rd_valid, 1'b0);
        chk("rst_wr_en", o_mem_wr_en, 1'b0);
        tick();
        i_rst      = 1'b0;
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_valid", o_rd_valid, 1'b0);
            chk("idle_ready", o_wr_ready, 1'b1);
            chk("idle_wr_en", o_mem_wr_en, 1'b0);
`ifdef FIFO_CTRL_LEVEL_EN
            chk("idle_level", o_level, 0);
`endif
            tick();
        end

        // Single push: visible exactly two cycles later.
        i_wr_valid = 1'b1;
        i_wr_data  = 8'hA5;
        i_rd_ready = 1'b1;
        #1;
        chk("one_valid_n", o_rd_valid, 1'b0);
        chk("one_wr_en", o_mem_wr_en, 1'b1);
        chk("one_wr_addr", o_mem_wr_addr, 4'h0);
        chk("one_wr_data", o_mem_wr_data, 8'hA5);
        tick();
        i_wr_valid = 1'b0;
        #1;
        chk("one_valid_n1", o_rd_valid, 1'b0);
`ifdef FIFO_CTRL_LEVEL_EN
        chk("one_level", o_level, 1);
`endif
        tick();
        #1;
        chk("one_valid_n2", o_rd_valid, 1'b1);
        chk("one_data_n2", o_rd_data, 8'hA5);
        tick();
        #1;
        chk("one_valid_n3", o_rd_valid, 1'b0);

        // Fill to full with 0x00..0x0F, no pops.
        i_rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            i_wr_valid = 1'b1;
            i_wr_data  = 8'(i);
            #1;
            chk("fill_ready", o_wr_ready, 1'b1);
        end
        tick();
        i_wr_valid = 1'b1;
        i_wr_data  = 8'hFF;
        #1;
        chk("full_ready", o_wr_ready, 1'b0);
        chk("full_wr_en", o_mem_wr_en, 1'b0);
`ifdef FIFO_CTRL_LEVEL_EN
        chk("full_level", o_level, 16);
`endif

        // Full with a simultaneous pop: push refused this cycle only.
        tick();
        i_wr_valid = 1'b1;
        i_wr_data  = 8'h55;
        i_rd_ready = 1'b1;
        #1;
        chk("fp_valid", o_rd_valid, 1'b1);
        chk("fp_data", o_rd_data, 8'h00);
        chk("fp_ready", o_wr_ready, 1'b0);
        chk("fp_wr_en", o_mem_wr_en, 1'b0);
        tick();
        #1;
        chk("fp_ready_next", o_wr_ready, 1'b1);
        chk("fp_wr_en_next", o_mem_wr_en, 1'b1);
        chk("fp_data_next", o_rd_data, 8'h01);
        for (int k = 2; k <= 16; k++) begin
            tick();
            i_wr_valid = 1'b0;
            #1;
            chk("drain_valid", o_rd_valid, 1'b1);
            chk("drain_data", o_rd_data, (k == 16) ? 8'h55 : 8'(k));
        end
        tick();
        #1;
        chk("drain_empty", o_rd_valid, 1'b0);
        i_rd_ready = 1'b0;

        // Random traffic, then both sides always active (no bubble).
        q.delete();
        run_traffic(100, 1'b0);
        run_traffic(40, 1'b1);

        // Reset with 7 stored entries and one push in flight.
        i_rd_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            i_wr_valid = 1'b1;
            i_wr_data  = 8'h80 + 8'(i);
            #1;
            chk("pre_rst_ready", o_wr_ready, 1'b1);
        end
        tick();
        i_wr_data = 8'hEE;
        #1;
        chk("inflight_wr_en", o_mem_wr_en, 1'b1);
        tick();
        i_rst      = 1'b1;
        i_rd_ready = 1'b1;
        #1;
        chk("mid_rst_ready", o_wr_ready, 1'b0);
        chk("mid_rst_valid", o_rd_valid, 1'b0);
        chk("mid_rst_wr_en", o_mem_wr_en, 1'b0);
        tick();
        i_rst     = 1'b0;
        i_wr_data = 8'h3C;
        #1;
        chk("post_rst_valid", o_rd_valid, 1'b0);
        chk("post_rst_ready", o_wr_ready, 1'b1);
        chk("post_rst_wr_en", o_mem_wr_en, 1'b1);
        tick();
        i_wr_valid = 1'b0;
        #1;
        chk("post_rst_valid1", o_rd_valid, 1'b0);
        tick();
        #1;
        chk("post_rst_valid2", o_rd_valid, 1'b1);
        chk("post_rst_data", o_rd_data, 8'h3C);
        tick();
        #1;
        chk("post_rst_empty", o_rd_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
